grf_sb: RTL
===========

# grf_sb

Parametrised general register file with an integrated per-register pending-write scoreboard, for the pipelined CPU datapath. It holds 2**ADDR_W registers of DATA_W bits and provides NRD combinational read ports and one writeback port. It also counts outstanding in-flight writes per register so decode can stall on RAW hazards. Register 0 is hardwired to zero and is never busy.

## Interface
Reset is synchronous and active-high (Reset); clock is Clk.

Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- NRD, 2, number of read ports
- PEND_W, 2, pending-counter width; max outstanding writes per register = 2**PEND_W-1

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high
- rd_addr  in  NRD*ADDR_W  read indices; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, packed the same way
- rd_busy  out  NRD  register has an outstanding write not yet forwardable
- issue_we  in  1  an instruction writing issue_addr leaves decode
- issue_addr  in  ADDR_W  destination register of the issued instruction
- issue_ready  out  1  issue_addr pending counter is not saturated
- wb_we  in  1  writeback strobe
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback value
- err_ovf  out  1  sticky flag: issue attempted while not ready
- err_unf  out  1  sticky flag: writeback to a register whose count is 0

## Operation
- Storage: array of 2**ADDR_W words.
  - On wb_we with wb_addr != 0, wb_data is written at the rising edge.
  - Writes to register 0 are dropped, and rd_data for index 0 is always 0.
- Pending count per register, cnt[r], updated at the rising edge:
  - An accepted issue (issue_we && issue_ready && issue_addr != 0) increments cnt[issue_addr].
  - A writeback (wb_we && wb_addr != 0) decrements cnt[wb_addr].
  - Issue and writeback to the same register in the same cycle leave cnt unchanged.
- issue_ready = (issue_addr == 0) || cnt[issue_addr] != max. It is combinational and does not account for a same-cycle writeback.
- Overflow: issue_we && !issue_ready leaves the count unchanged and sets err_ovf.
- Underflow: a writeback while cnt == 0 still writes the data, keeps cnt at 0 and sets err_unf.
- err_ovf and err_unf are cleared only by Reset.
- rd_busy[i] = cnt[rd_addr[i]] != 0, subject to the bypass rule under Configuration. A same-cycle issue does not affect rd_busy.
- Reset values:
  - all registers 0 and all cnt 0
  - rd_data = 0, rd_busy = 0, issue_ready = 1
  - err_ovf = 0, err_unf = 0
- Reset dominates all same-cycle issue and writeback activity.

## Timing
- Read path is fully combinational: address to rd_data, rd_busy and issue_ready within the same cycle.
- Without bypass, write-to-read latency is 1 cycle: new data is visible in the cycle after wb_we.
- Counters take effect 1 cycle after the edge at which the issue or writeback is sampled.
- Reset asserted mid-operation clears all state at the next edge. Outstanding writebacks that arrive afterwards set err_unf.
- All ports may read the same address, including wb_addr, in the same cycle.

## Configuration
- GRF_BYPASS_EN defined:
  - When wb_we && wb_addr == rd_addr[i] && wb_addr != 0, rd_data[i] = wb_data in the same cycle.
  - In that case rd_busy[i] is 0 when cnt == 1 (the last pending write is the one completing).
  - When cnt > 1, rd_busy[i] stays 1.
- GRF_BYPASS_EN undefined:
  - rd_data always comes from the array.
  - rd_busy[i] = cnt != 0, and write-to-read latency is 1 cycle.

## Structure
- Shared package grf_pkg holds:
  - defaults for DATA_W, ADDR_W and PEND_W
  - localparam function for PEND_MAX
  - a zero-register index constant
- One natural sub-module, grf_pend_ctr: a single saturating up/down counter with inc, dec and simultaneous-hold behaviour, and with ovf/unf pulse outputs.
  - grf_sb instantiates 2**ADDR_W - 1 copies via generate; register 0 has no counter.
  - grf_sb ORs the pulses into the sticky flags.

## Test plan
- Reset, then read all indices: rd_data = 0 and rd_busy = 0 on every port; issue_ready = 1.
- Write r5 = 0xDEADBEEF, then on the next cycle read r5 on both ports: 0xDEADBEEF on both. Write r0 = 0x1234: r0 still reads 0.
- Issue r3 three times (PEND_W = 2), then issue r3 a fourth time: issue_ready = 0 and err_ovf = 1. Three writebacks to r3: rd_busy drops after the third.
- Same-cycle issue and writeback on r7 with cnt = 1: cnt stays 1 and rd_busy = 1.
- With GRF_BYPASS_EN, cnt[r9] = 1, write r9 = 0xA5A5A5A5 and read r9 in the same cycle: rd_data = 0xA5A5A5A5 and rd_busy = 0. Without the macro: old value is returned and rd_busy = 1.
- Writeback r4 = 0x1 with cnt 0: r4 = 1 and err_unf = 1. Assert Reset mid-stream: all outputs return to their reset values at the next edge.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared defaults and helpers for the general register file with pending-write scoreboard.
package grf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int PEND_W_DEF = 2;
    localparam int NRD_DEF    = 2;
    localparam int ZERO_REG   = 0;

    function automatic int pend_max(input int pend_w);
        return (1 << pend_w) - 1;
    endfunction

endpackage

// File: rtl/grf_sb_if.sv
// Read, issue, writeback and error signals of the register file; master drives, slave is the file.
interface grf_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  issue_we;
    logic [ADDR_W-1:0]     issue_addr;
    logic                  issue_ready;
    logic                  wb_we;
    logic [ADDR_W-1:0]     wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic                  err_ovf;
    logic                  err_unf;

    modport master (
        output rd_addr, issue_we, issue_addr, wb_we, wb_addr, wb_data,
        input  rd_data, rd_busy, issue_ready, err_ovf, err_unf
    );

    modport slave (
        input  rd_addr, issue_we, issue_addr, wb_we, wb_addr, wb_data,
        output rd_data, rd_busy, issue_ready, err_ovf, err_unf
    );
endinterface

// File: rtl/grf_pend_ctr.sv
// Saturating up/down count of in-flight writes to one register, with overflow/underflow pulses.
module grf_pend_ctr
    import grf_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [PEND_W-1:0] cnt_o,
    output logic              ovf_o,
    output logic              unf_o
);
    localparam logic [PEND_W-1:0] MAX_V = PEND_W'(pend_max(PEND_W));

    logic [PEND_W-1:0] cnt_q, cnt_d;
    logic              sat_s, empty_s, inc_ok_s;

    assign sat_s    = (cnt_q == MAX_V);
    assign empty_s  = (cnt_q == '0);
    assign inc_ok_s = inc_i && !sat_s;
    assign ovf_o    = inc_i && sat_s;
    assign unf_o    = dec_i && empty_s;
    assign cnt_o    = cnt_q;

    // Next count: a rejected issue never counts, so a saturated issue plus writeback still decrements.
    always_comb begin
        cnt_d = cnt_q;
        case ({inc_ok_s, dec_i})
            2'b10:   cnt_d = cnt_q + PEND_W'(1);
            2'b01: begin
                if (!empty_s) cnt_d = cnt_q - PEND_W'(1);
                else          cnt_d = cnt_q;
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // Count register.
    always_ff @(posedge Clk) begin
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/grf_sb.sv
// Register file with per-register pending-write counters for RAW stalls; r0 reads zero, never busy.
// Define GRF_BYPASS_EN to forward a same-cycle writeback to the read ports.
module grf_sb
    import grf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic     Clk,
    input  logic     Reset,
    grf_sb_if.slave  bus
);
    localparam int                DEPTH      = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX_V = PEND_W'(pend_max(PEND_W));
    localparam logic [ADDR_W-1:0] ZERO_IDX   = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0]             mem_q [DEPTH];
    logic [DATA_W-1:0]             mem_d [DEPTH];
    logic [DEPTH-1:0][PEND_W-1:0]  cnt_s;
    logic [DEPTH-1:0]              ovf_s, unf_s;
    logic                          err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;
    logic                          wb_hit_s;

    assign wb_hit_s = bus.wb_we && (bus.wb_addr != ZERO_IDX);

    // Storage next-state; r0 is held at zero.
    always_comb begin
        mem_d = mem_q;
        if (wb_hit_s) mem_d[bus.wb_addr] = bus.wb_data;
        else          mem_d[ZERO_IDX]    = '0;
    end

    // Sticky error flags collect every counter's pulses.
    always_comb begin
        err_ovf_d = err_ovf_q | (|ovf_s);
        err_unf_d = err_unf_q | (|unf_s);
    end

    // Storage and error flag registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign cnt_s[0] = '0;
    assign ovf_s[0] = 1'b0;
    assign unf_s[0] = 1'b0;

    for (genvar r = 1; r < DEPTH; r++) begin : g_ctr
        grf_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
            .Clk   (Clk),
            .Reset (Reset),
            .inc_i (bus.issue_we && (bus.issue_addr == ADDR_W'(r))),
            .dec_i (bus.wb_we && (bus.wb_addr == ADDR_W'(r))),
            .cnt_o (cnt_s[r]),
            .ovf_o (ovf_s[r]),
            .unf_o (unf_s[r])
        );
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic [PEND_W-1:0] cnt_rd_s;
        logic [DATA_W-1:0] data_s;
        logic              busy_s;

        assign addr_s   = bus.rd_addr[i*ADDR_W +: ADDR_W];
        assign cnt_rd_s = cnt_s[addr_s];

        // Read mux: with bypass, a completing writeback clears busy only if it is the last one pending.
        always_comb begin
            data_s = '0;
            busy_s = 1'b0;
            if (addr_s == ZERO_IDX) begin
                data_s = '0;
                busy_s = 1'b0;
            end
`ifdef GRF_BYPASS_EN
            else if (wb_hit_s && (bus.wb_addr == addr_s)) begin
                data_s = bus.wb_data;
                busy_s = (cnt_rd_s > PEND_W'(1));
            end
`endif
            else begin
                data_s = mem_q[addr_s];
                busy_s = (cnt_rd_s != '0);
            end
        end

        assign bus.rd_data[i*DATA_W +: DATA_W] = data_s;
        assign bus.rd_busy[i]                  = busy_s;
    end

    assign bus.issue_ready = (bus.issue_addr == ZERO_IDX) || (cnt_s[bus.issue_addr] != PEND_MAX_V);
    assign bus.err_ovf     = err_ovf_q;
    assign bus.err_unf     = err_unf_q;
endmodule
